// File: rtl/leds_write_arbiter.sv
// Purpose: round-robin arbiter sharing one LED PIO register among NREQ requesters, write then read-back verify.
// Latency: req seen in IDLE at cycle t -> write strobe t+1, ack t+2; grants spaced >= 3 + HOLD_CYCLES cycles.
// Backpressure: requesters hold req/data until ack; pending requests wait through WRITE/VERIFY/HOLD.
module leds_write_arbiter #(
    parameter int NREQ        = 3,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic              busy,
    output logic              err,
    input  logic              clr_err,
    output logic [7:0]        led_shadow,
    output logic [1:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // The hold counter counts down from HOLD_CYCLES to 1, so it never wraps.
    localparam int CW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] HOLD_ONE  = CW'(1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
        S_VERIFY = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] cand;
    logic          pick_vld;
    logic [7:0]    gnt_dat;
    logic [CW-1:0] hold_cnt;
    logic          rd_mismatch;
    logic [7:0]    req_byte [NREQ];

    // Split the packed request data into one byte per requester.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_byte[i] = req_data[8*i +: 8];
        end
    end

    // Round-robin pick: scan downward so the requester nearest at/after rr_ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IW'((32'(rr_ptr) + 32'(k)) % 32'(NREQ));
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Upper read-back bits must be zero too, so compare the full word.
    assign rd_mismatch = (avm_readdata != {24'b0, gnt_dat});

    // Next-state logic for the write / verify / hold sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (pick_vld) state_nxt = S_WRITE;
            S_WRITE:  state_nxt = S_VERIFY;
            S_VERIFY: state_nxt = (HOLD_CYCLES == 0) ? S_IDLE : S_HOLD;
            S_HOLD:   if (hold_cnt == HOLD_ONE) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant latch: index and data are captured once, at grant time only.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_idx <= '0;
            gnt_dat <= '0;
        end else if (state == S_IDLE && pick_vld) begin
            gnt_idx <= pick_idx;
            gnt_dat <= req_byte[pick_idx];
        end
    end

    // Round-robin pointer moves past the served requester when it is acked.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (state == S_VERIFY) begin
            rr_ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IW'(1);
        end
    end

    // Hold-off counter: loaded in VERIFY, counts down while in HOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (state == S_VERIFY) begin
            hold_cnt <= HOLD_LOAD;
        end else if (state == S_HOLD) begin
            hold_cnt <= hold_cnt - HOLD_ONE;
        end
    end

    // Shadow copy of the displayed pattern, taken as the write completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_shadow <= '0;
        end else if (state == S_WRITE) begin
            led_shadow <= gnt_dat;
        end
    end

    // Sticky verify-error flag; a new mismatch beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (state == S_VERIFY && rd_mismatch) begin
            err <= 1'b1;
        end else if (clr_err) begin
            err <= 1'b0;
        end
    end

    // Bus strobes and ack decoded from the current state.
    always_comb begin
        ack            = '0;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_writedata  = '0;
        busy           = (state != S_IDLE);
        case (state)
            S_WRITE: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_writedata  = {24'b0, gnt_dat};
            end
            S_VERIFY: begin
                avm_chipselect = 1'b1;
                ack[gnt_idx]   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign avm_address = 2'b00;

endmodule

// File: tb/tb_leds_write_arbiter.sv
// Purpose: self-checking bench for leds_write_arbiter (HOLD_CYCLES=4 and HOLD_CYCLES=0 instances).
// Latency: checks sampled 1 time unit after each rising clk edge.
// Backpressure: bench requesters hold req/data until ack, as a real client would.
module tb_leds_write_arbiter;

    localparam int H = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with HOLD_CYCLES = 4
    logic        a_reset = 1'b1;
    logic [2:0]  a_req   = '0;
    logic [23:0] a_data  = '0;
    logic        a_clr   = 1'b0;
    logic [2:0]  a_ack;
    logic        a_busy, a_err, a_cs, a_wn;
    logic [7:0]  a_led;
    logic [1:0]  a_addr;
    logic [31:0] a_wd, a_rd;
    logic [31:0] a_reg    = '0;
    logic        a_bad    = 1'b0;
    logic [31:0] a_badval = '0;

    // Instance with HOLD_CYCLES = 0
    logic        z_reset = 1'b1;
    logic [2:0]  z_req   = '0;
    logic [23:0] z_data  = '0;
    logic        z_clr   = 1'b0;
    logic [2:0]  z_ack;
    logic        z_busy, z_err, z_cs, z_wn;
    logic [7:0]  z_led;
    logic [1:0]  z_addr;
    logic [31:0] z_wd, z_rd;
    logic [31:0] z_reg = '0;

    leds_write_arbiter #(.NREQ(3), .HOLD_CYCLES(H)) dut (
        .clk(clk), .reset(a_reset), .req(a_req), .req_data(a_data),
        .ack(a_ack), .busy(a_busy), .err(a_err), .clr_err(a_clr),
        .led_shadow(a_led), .avm_address(a_addr), .avm_chipselect(a_cs),
        .avm_write_n(a_wn), .avm_writedata(a_wd), .avm_readdata(a_rd)
    );

    leds_write_arbiter #(.NREQ(3), .HOLD_CYCLES(0)) dut_z (
        .clk(clk), .reset(z_reset), .req(z_req), .req_data(z_data),
        .ack(z_ack), .busy(z_busy), .err(z_err), .clr_err(z_clr),
        .led_shadow(z_led), .avm_address(z_addr), .avm_chipselect(z_cs),
        .avm_write_n(z_wn), .avm_writedata(z_wd), .avm_readdata(z_rd)
    );

    // PIO slave models: register the write, read back combinationally (optionally corrupted).
    always @(posedge clk) if (a_cs && !a_wn) a_reg <= a_wd;
    always @(posedge clk) if (z_cs && !z_wn) z_reg <= z_wd;
    assign a_rd = a_bad ? a_badval : a_reg;
    assign z_rd = z_reg;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output logic [2:0] got);
        got = '0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (a_ack != 3'b000) begin
                got = a_ack;
                return;
            end
        end
    endtask

    task automatic wait_idle(input string nm);
        for (int c = 0; c < 40; c++) begin
            if (!a_busy) break;
            step();
        end
        chk(nm, a_busy, 1'b0);
    endtask

    task automatic pulse_clr();
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
    endtask

    typedef struct packed {
        logic [2:0]  req;
        logic [23:0] data;     // {d2, d1, d0}
        logic [2:0]  exp_ack;
        logic [7:0]  exp_pat;
    } vec_t;

    vec_t        tv [7];
    logic [2:0]  got;
    logic [2:0]  acc;
    int          busy_n, to, k, last_c;
    // random-phase reference model
    int          m_rr, m_gnt, m_win;
    logic [7:0]  m_data, m_led;
    logic        m_err;
    logic [2:0]  r_req;
    logic [7:0]  rd [3];
    logic        e_wr, e_vf, e_busy;
    logic [2:0]  e_ack;
    logic [7:0]  prev_dat;
    int          n_wr;

    initial begin
        // Expected winners follow the rr pointer, which starts at 0 after reset.
        tv[0] = '{3'b001, 24'h0000A5, 3'b001, 8'hA5};
        tv[1] = '{3'b111, 24'h332211, 3'b010, 8'h22};
        tv[2] = '{3'b011, 24'h665544, 3'b001, 8'h44};
        tv[3] = '{3'b101, 24'h998877, 3'b100, 8'h99};
        tv[4] = '{3'b110, 24'h030201, 3'b010, 8'h02};
        tv[5] = '{3'b100, 24'hC30000, 3'b100, 8'hC3};
        tv[6] = '{3'b111, 24'hF2F1F0, 3'b001, 8'hF0};

        // ---- reset values ----
        step();
        step();
        chk("rst_cs", a_cs, 1'b0);
        chk("rst_wn", a_wn, 1'b1);
        chk("rst_ack", a_ack, 3'b000);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_err", a_err, 1'b0);
        chk("rst_led", a_led, 8'h00);
        chk("rst_wd", a_wd, 32'h0);
        chk("rst_addr", a_addr, 2'b00);
        chk("rst_z_busy", z_busy, 1'b0);
        a_reset = 1'b0;
        z_reset = 1'b0;

        // ---- table-driven single transactions ----
        for (int v = 0; v < 7; v++) begin
            a_req  = tv[v].req;
            a_data = tv[v].data;
            step();
            chk($sformatf("vec%0d_wr_n", v), a_wn, 1'b0);
            chk($sformatf("vec%0d_wdata", v), a_wd, {24'b0, tv[v].exp_pat});
            busy_n = int'(a_busy);
            step();
            chk($sformatf("vec%0d_ack", v), a_ack, tv[v].exp_ack);
            busy_n += int'(a_busy);
            a_req = 3'b000;
            to = 1;
            for (int c = 0; c < 40; c++) begin
                step();
                if (!a_busy) begin
                    to = 0;
                    break;
                end
                busy_n++;
            end
            chk($sformatf("vec%0d_idle_timeout", v), to, 0);
            chk($sformatf("vec%0d_busy_cycles", v), busy_n, 2 + H);
            chk($sformatf("vec%0d_led", v), a_led, tv[v].exp_pat);
            chk($sformatf("vec%0d_err", v), a_err, 1'b0);
        end

        // ---- three requesters held continuously ----
        a_reset = 1'b1;
        step();
        a_reset = 1'b0;
        a_req  = 3'b111;
        a_data = 24'h332211;
        k = 0;
        last_c = 0;
        for (int c = 1; c <= 60; c++) begin
            step();
            chk("cont_one_hot", ($countones(a_ack) <= 1), 1'b1);
            if (a_ack != 3'b000) begin
                chk($sformatf("cont_order%0d", k), a_ack, 3'b001 << (k % 3));
                if (k > 0) chk($sformatf("cont_spacing%0d", k), c - last_c, 3 + H);
                last_c = c;
                k++;
            end
        end
        chk("cont_ack_count", k, 9);
        a_req = 3'b000;
        wait_idle("cont_idle");

        // ---- requester 2 re-requests while 1 waits ----
        a_req  = 3'b100;
        a_data = 24'h0C0B0A;
        step();
        a_req = 3'b110;
        wait_ack(got);
        chk("fair_first", got, 3'b100);
        wait_ack(got);
        chk("fair_second", got, 3'b010);
        a_req = 3'b100;
        wait_ack(got);
        chk("fair_third", got, 3'b100);
        a_req = 3'b000;
        wait_idle("fair_idle");

        // ---- err flag ----
        a_bad = 1'b1;
        a_badval = 32'h0000_00FF;
        a_req = 3'b001;
        a_data = 24'h00000F;
        wait_ack(got);
        a_req = 3'b000;
        step();
        a_bad = 1'b0;
        chk("err_set", a_err, 1'b1);
        wait_idle("err_idle1");
        a_req = 3'b010;
        a_data = 24'h002200;
        wait_ack(got);
        a_req = 3'b000;
        step();
        chk("err_sticky", a_err, 1'b1);
        wait_idle("err_idle2");
        pulse_clr();
        chk("err_clr", a_err, 1'b0);
        a_bad = 1'b1;
        a_badval = 32'h0;
        a_req = 3'b100;
        a_data = 24'h770000;
        wait_ack(got);
        a_clr = 1'b1;
        a_req = 3'b000;
        step();
        a_clr = 1'b0;
        a_bad = 1'b0;
        chk("err_set_wins", a_err, 1'b1);
        wait_idle("err_idle3");
        pulse_clr();
        chk("err_clr2", a_err, 1'b0);
        a_bad = 1'b1;
        a_badval = 32'h0100_005A;
        a_req = 3'b001;
        a_data = 24'h00005A;
        wait_ack(got);
        a_req = 3'b000;
        step();
        a_bad = 1'b0;
        chk("err_upper_bits", a_err, 1'b1);
        wait_idle("err_idle4");
        pulse_clr();

        // ---- reset during HOLD ----
        a_req = 3'b001;
        a_data = 24'h00003C;
        wait_ack(got);
        a_req = 3'b000;
        step();
        a_reset = 1'b1;
        step();
        a_reset = 1'b0;
        chk("rh_cs", a_cs, 1'b0);
        chk("rh_wn", a_wn, 1'b1);
        chk("rh_ack", a_ack, 3'b000);
        chk("rh_busy", a_busy, 1'b0);
        chk("rh_led", a_led, 8'h00);
        a_req = 3'b111;
        a_data = 24'h030201;
        wait_ack(got);
        chk("rh_rr_zero", got, 3'b001);
        a_req = 3'b000;
        wait_idle("rh_idle");

        // ---- reset during WRITE ----
        a_req = 3'b010;
        a_data = 24'h00AB00;
        step();
        chk("rw_in_write", a_wn, 1'b0);
        a_reset = 1'b1;
        a_req = 3'b000;
        step();
        a_reset = 1'b0;
        chk("rw_cs", a_cs, 1'b0);
        chk("rw_wn", a_wn, 1'b1);
        chk("rw_ack", a_ack, 3'b000);
        chk("rw_busy", a_busy, 1'b0);
        chk("rw_led", a_led, 8'h00);
        acc = '0;
        for (int c = 0; c < 10; c++) begin
            step();
            acc |= a_ack;
        end
        chk("rw_no_ack", acc, 3'b000);
        chk("rw_led_after", a_led, 8'h00);
        a_req = 3'b111;
        a_data = 24'h030201;
        wait_ack(got);
        chk("rw_rr_zero", got, 3'b001);
        a_req = 3'b000;

        // ---- randomized traffic against a timeline model ----
        a_reset = 1'b1;
        step();
        a_reset = 1'b0;
        m_rr = 0; m_gnt = -100; m_win = 0; m_data = '0; m_led = '0; m_err = 1'b0;
        r_req = '0;
        for (int i = 0; i < 3; i++) rd[i] = '0;
        for (int n = 0; n < 1500; n++) begin
            e_wr   = (n == m_gnt + 1);
            e_vf   = (n == m_gnt + 2);
            e_ack  = e_vf ? (3'b001 << m_win) : 3'b000;
            e_busy = (n > m_gnt) && (n < m_gnt + 3 + H);
            chk("rnd_ack", a_ack, e_ack);
            chk("rnd_wr_n", a_wn, !e_wr);
            chk("rnd_cs", a_cs, e_wr || e_vf);
            chk("rnd_wdata", a_wd, e_wr ? {24'b0, m_data} : 32'h0);
            chk("rnd_busy", a_busy, e_busy);
            chk("rnd_err", a_err, m_err);
            chk("rnd_led", a_led, m_led);

            for (int i = 0; i < 3; i++) begin
                if (n == m_gnt + 3 && i == m_win) begin
                    if ($urandom_range(1, 0) == 1) rd[i] = 8'($urandom);
                    else r_req[i] = 1'b0;
                end else if (!r_req[i]) begin
                    if ($urandom_range(3, 0) == 0) begin
                        r_req[i] = 1'b1;
                        rd[i] = 8'($urandom);
                    end
                end else if (i == m_win && n == m_gnt + 1 && $urandom_range(7, 0) == 0) begin
                    r_req[i] = 1'b0;
                end
            end
            a_clr    = ($urandom_range(15, 0) == 0);
            a_bad    = ($urandom_range(5, 0) == 0);
            a_badval = ($urandom_range(1, 0) == 1) ? {24'b0, 8'($urandom)} : 32'($urandom);
            a_req    = r_req;
            a_data   = {rd[2], rd[1], rd[0]};

            if (e_wr) m_led = m_data;
            if (e_vf && a_bad && a_badval != {24'b0, m_data}) m_err = 1'b1;
            else if (a_clr) m_err = 1'b0;
            if (e_vf) m_rr = (m_win + 1) % 3;
            if (n >= m_gnt + 3 + H && r_req != 3'b000) begin
                for (int j = 2; j >= 0; j--) begin
                    if (r_req[(m_rr + j) % 3]) m_win = (m_rr + j) % 3;
                end
                m_gnt  = n;
                m_data = rd[m_win];
            end
            step();
        end
        a_req = 3'b000;
        a_clr = 1'b0;
        a_bad = 1'b0;

        // ---- HOLD_CYCLES = 0: back-to-back, data changes after grant ----
        z_req = 3'b001;
        prev_dat = 8'h10;
        z_data = {16'b0, prev_dat};
        n_wr = 0;
        for (int c = 1; c <= 13; c++) begin
            step();
            chk("z_wr_n", z_wn, (c % 3 == 1) ? 1'b0 : 1'b1);
            chk("z_ack", z_ack, (c % 3 == 2) ? 3'b001 : 3'b000);
            if (c % 3 == 1) begin
                chk("z_wdata_old", z_wd, {24'b0, prev_dat});
                n_wr++;
            end
            prev_dat = 8'h10 + 8'(c);
            z_data = {16'b0, prev_dat};
        end
        chk("z_write_count", n_wr, 5);
        chk("z_err", z_err, 1'b0);
        z_req = 3'b000;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
